csr_fwd_ctrl: RTL and testbench

//  Hazard/forwarding controller for the CSR-instruction operand path.
//  - Shadows destination info of in-flight instrs (EX, MEM, WB, WB_TEMP).
//  - Generates registered select codes for the CSR rs1/value forwarding mux in EX.
//  - Stalls ID for one cycle on a load-use hazard against a CSR instruction's rs1.

---
 rtl/csr_fwd_pkg.sv | 54 +++++
 rtl/csr_fwd_cmp.sv | 25 ++
 rtl/csr_fwd_ctrl.sv | 171 +++++++++++++++++
 tb/tb_csr_fwd_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_fwd_pkg.sv
// Shared select codes, FSM state type and shadow-entry layout for the CSR
// forwarding controller.
package csr_fwd_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int CSR_AW_DEF = 12;

  localparam logic [2:0] FWD1_RF      = 3'd0;
  localparam logic [2:0] FWD1_MEM_ALU = 3'd1;
  localparam logic [2:0] FWD1_WB_ALU  = 3'd2;
  localparam logic [2:0] FWD1_WB_MEM  = 3'd3;
  localparam logic [2:0] FWD1_WBT_MEM = 3'd4;
  localparam logic [2:0] FWD1_WBT_ALU = 3'd5;

  localparam logic [1:0] FWD2_EX  = 2'd0;
  localparam logic [1:0] FWD2_MEM = 2'd1;
  localparam logic [1:0] FWD2_WB  = 2'd2;
  localparam logic [1:0] FWD2_WBT = 2'd3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } fsm_state_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] rd;
    logic                  rd_we;
    logic                  is_load;
    logic [CSR_AW_DEF-1:0] csr_addr;
    logic                  csr_we;
  } shadow_t;

  localparam int SHADOW_W = $bits(shadow_t);

  function automatic shadow_t make_entry(
    input logic                  valid,
    input logic [REG_AW_DEF-1:0] rd,
    input logic                  rd_we,
    input logic                  is_load,
    input logic [CSR_AW_DEF-1:0] csr_addr,
    input logic                  csr_we
  );
    shadow_t e;
    e.valid    = valid;
    e.rd       = rd;
    e.rd_we    = rd_we;
    e.is_load  = is_load;
    e.csr_addr = csr_addr;
    e.csr_we   = csr_we;
    return e;
  endfunction

endpackage

// File: rtl/csr_fwd_cmp.sv
// Compares one in-flight shadow entry against the CSR instruction in ID:
// GPR rs1 hit (and whether the producer is a load) plus CSR address hit.
module csr_fwd_cmp #(
  parameter int REG_AW = 5,
  parameter int CSR_AW = 12
) (
  input  logic              valid,
  input  logic [REG_AW-1:0] rd,
  input  logic              rd_we,
  input  logic              is_load,
  input  logic [CSR_AW-1:0] csr_addr,
  input  logic              csr_we,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [CSR_AW-1:0] id_csr_addr,
  output logic              rs1_hit,
  output logic              rs1_load,
  output logic              csr_hit
);

  // x0 is hard-wired zero, so a write to it never forwards
  assign rs1_hit  = valid & rd_we & (rd != {REG_AW{1'b0}}) & (rd == id_rs1);
  assign rs1_load = is_load;
  assign csr_hit  = valid & csr_we & (csr_addr == id_csr_addr);

endmodule

// File: rtl/csr_fwd_ctrl.sv
// CSR operand hazard/forwarding controller. Optional event counters are
// built when the macro CSR_FWD_STATS_EN is defined.
module csr_fwd_ctrl
  import csr_fwd_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int CSR_AW = CSR_AW_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              id_is_csr,
  input  logic              id_rs1_used,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [CSR_AW-1:0] id_csr_addr,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              id_csr_we,
  output logic [2:0]        forward_csr_signal1,
  output logic [1:0]        forward_csr_signal2,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic [CNT_W-1:0]  stat_stalls,
  output logic [CNT_W-1:0]  stat_fwd
);

  // A WB_TEMP producer is reached through the wb_r hit registered one cycle
  // earlier, so no separate WB_TEMP shadow needs to be kept.
  shadow_t    ex_r, mem_r, wb_r, id_entry_s;
  shadow_t    stage_s [3];
  fsm_state_t state_r, state_nxt_s;
  logic [2:0] sel1_r, sel1_nxt_s;
  logic [1:0] sel2_r, sel2_nxt_s;
  logic [2:0] rs1_hit_s, rs1_load_s, csr_hit_s;
  logic       rs1_req_s, hazard_s;

  assign id_entry_s = make_entry(id_valid, id_rd, id_rd_we, id_is_load,
                                 id_csr_addr, id_csr_we);
  assign stage_s[0] = ex_r;
  assign stage_s[1] = mem_r;
  assign stage_s[2] = wb_r;

  for (genvar g = 0; g < 3; g++) begin : g_cmp
    csr_fwd_cmp #(.REG_AW(REG_AW), .CSR_AW(CSR_AW)) u_cmp (
      .valid       (stage_s[g].valid),
      .rd          (stage_s[g].rd),
      .rd_we       (stage_s[g].rd_we),
      .is_load     (stage_s[g].is_load),
      .csr_addr    (stage_s[g].csr_addr),
      .csr_we      (stage_s[g].csr_we),
      .id_rs1      (id_rs1),
      .id_csr_addr (id_csr_addr),
      .rs1_hit     (rs1_hit_s[g]),
      .rs1_load    (rs1_load_s[g]),
      .csr_hit     (csr_hit_s[g])
    );
  end

  assign rs1_req_s = id_is_csr & id_rs1_used;

  // Priority-encode the forwarding sources as seen from ID (youngest first)
  always_comb begin
    sel1_nxt_s = FWD1_RF;
    hazard_s   = 1'b0;
    if (!rs1_req_s) begin
      sel1_nxt_s = FWD1_RF;
    end else if (rs1_hit_s[0]) begin
      if (rs1_load_s[0]) begin
        hazard_s = 1'b1;
      end else begin
        sel1_nxt_s = FWD1_MEM_ALU;
      end
    end else if (rs1_hit_s[1]) begin
      sel1_nxt_s = rs1_load_s[1] ? FWD1_WB_MEM : FWD1_WB_ALU;
    end else if (rs1_hit_s[2]) begin
      sel1_nxt_s = rs1_load_s[2] ? FWD1_WBT_MEM : FWD1_WBT_ALU;
    end else begin
      sel1_nxt_s = FWD1_RF;
    end

    sel2_nxt_s = FWD2_EX;
    if (csr_hit_s[0]) begin
      sel2_nxt_s = FWD2_MEM;
    end else if (csr_hit_s[1]) begin
      sel2_nxt_s = FWD2_WB;
    end else if (csr_hit_s[2]) begin
      sel2_nxt_s = FWD2_WBT;
    end else begin
      sel2_nxt_s = FWD2_EX;
    end
  end

  // Load-use stall FSM: one stall cycle per hazard, flush always wins
  always_comb begin
    state_nxt_s = state_r;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (hazard_s && id_valid && !flush) begin
          stall_id    = 1'b1;
          bubble_ex   = 1'b1;
          state_nxt_s = ST_STALL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_STALL: state_nxt_s = ST_RUN;
      default:  state_nxt_s = ST_RUN;
    endcase
  end

  // Shadow pipeline, registered selects and FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_r    <= '0;
      mem_r   <= '0;
      wb_r    <= '0;
      sel1_r  <= FWD1_RF;
      sel2_r  <= FWD2_EX;
      state_r <= ST_RUN;
    end else if (flush) begin
      ex_r    <= '0;
      mem_r   <= '0;
      wb_r    <= mem_r;
      sel1_r  <= FWD1_RF;
      sel2_r  <= FWD2_EX;
      state_r <= ST_RUN;
    end else if (!hold) begin
      wb_r    <= mem_r;
      mem_r   <= ex_r;
      ex_r    <= bubble_ex ? '0 : id_entry_s;
      sel1_r  <= bubble_ex ? FWD1_RF : sel1_nxt_s;
      sel2_r  <= bubble_ex ? FWD2_EX : sel2_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  assign forward_csr_signal1 = sel1_r;
  assign forward_csr_signal2 = sel2_r;

`ifdef CSR_FWD_STATS_EN
  logic [CNT_W-1:0] stat_stalls_r, stat_fwd_r;

  // Event counters; wrap naturally at 2^CNT_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stalls_r <= {CNT_W{1'b0}};
      stat_fwd_r    <= {CNT_W{1'b0}};
    end else if (!hold) begin
      if (state_r == ST_RUN && stall_id) begin
        stat_stalls_r <= stat_stalls_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (ex_r.valid && (sel1_r != FWD1_RF || sel2_r != FWD2_EX)) begin
        stat_fwd_r <= stat_fwd_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stat_stalls = stat_stalls_r;
  assign stat_fwd    = stat_fwd_r;
`else
  assign stat_stalls = {CNT_W{1'b0}};
  assign stat_fwd    = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_csr_fwd_ctrl.sv
// Directed testbench for csr_fwd_ctrl: hand-computed forwarding selects,
// load-use stall, flush, hold and asynchronous reset behaviour.
module tb_csr_fwd_ctrl;

  logic        clk = 1'b0;
  logic        rst, hold, flush;
  logic        id_valid, id_is_csr, id_rs1_used;
  logic [4:0]  id_rs1, id_rd;
  logic [11:0] id_csr_addr;
  logic        id_rd_we, id_is_load, id_csr_we;
  logic [2:0]  forward_csr_signal1;
  logic [1:0]  forward_csr_signal2;
  logic        stall_id, bubble_ex;
  logic [31:0] stat_stalls, stat_fwd;

  int checks = 0;
  int errors = 0;

  csr_fwd_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .hold                (hold),
    .flush               (flush),
    .id_valid            (id_valid),
    .id_is_csr           (id_is_csr),
    .id_rs1_used         (id_rs1_used),
    .id_rs1              (id_rs1),
    .id_csr_addr         (id_csr_addr),
    .id_rd               (id_rd),
    .id_rd_we            (id_rd_we),
    .id_is_load          (id_is_load),
    .id_csr_we           (id_csr_we),
    .forward_csr_signal1 (forward_csr_signal1),
    .forward_csr_signal2 (forward_csr_signal2),
    .stall_id            (stall_id),
    .bubble_ex           (bubble_ex),
    .stat_stalls         (stat_stalls),
    .stat_fwd            (stat_fwd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid    = 1'b0;
    id_is_csr   = 1'b0;
    id_rs1_used = 1'b0;
    id_rs1      = 5'd0;
    id_csr_addr = 12'h000;
    id_rd       = 5'd0;
    id_rd_we    = 1'b0;
    id_is_load  = 1'b0;
    id_csr_we   = 1'b0;
  endtask

  task automatic id_alu(input logic [4:0] rd);
    id_clear();
    id_valid = 1'b1;
    id_rd    = rd;
    id_rd_we = 1'b1;
  endtask

  task automatic id_load(input logic [4:0] rd);
    id_alu(rd);
    id_is_load = 1'b1;
  endtask

  task automatic id_csr(input logic [4:0] rs1, input logic [11:0] addr,
                        input logic [4:0] rd, input logic csr_we);
    id_clear();
    id_valid    = 1'b1;
    id_is_csr   = 1'b1;
    id_rs1_used = 1'b1;
    id_rs1      = rs1;
    id_csr_addr = addr;
    id_rd       = rd;
    id_rd_we    = (rd != 5'd0);
    id_csr_we   = csr_we;
  endtask

  task automatic drain();
    id_clear();
    repeat (4) tick();
  endtask

  initial begin
    rst   = 1'b1;
    hold  = 1'b0;
    flush = 1'b0;
    id_clear();
    #12;
    check_eq("rst_sel1", 32'(forward_csr_signal1), 32'd0);
    check_eq("rst_sel2", 32'(forward_csr_signal2), 32'd0);
    check_eq("rst_stall", 32'(stall_id), 32'd0);
    check_eq("rst_bubble", 32'(bubble_ex), 32'd0);
    check_eq("rst_stat_stalls", stat_stalls, 32'd0);
    check_eq("rst_stat_fwd", stat_fwd, 32'd0);
    #1 rst = 1'b0;

    // 1: ALU x5 then csrrw x0,mstatus,x5
    id_alu(5'd5);
    tick();
    id_csr(5'd5, 12'h300, 5'd0, 1'b1);
    #1 check_eq("t1_no_stall", 32'(stall_id), 32'd0);
    tick();
    check_eq("t1_sel1_mem_alu", 32'(forward_csr_signal1), 32'd1);
    check_eq("t1_sel2", 32'(forward_csr_signal2), 32'd0);
    drain();

    // 2: lw x6 then csrrs x0,mtvec,x6
    id_load(5'd6);
    tick();
    id_csr(5'd6, 12'h305, 5'd0, 1'b1);
    #1 check_eq("t2_stall", 32'(stall_id), 32'd1);
    check_eq("t2_bubble", 32'(bubble_ex), 32'd1);
    tick();
    check_eq("t2_stall_done", 32'(stall_id), 32'd0);
    check_eq("t2_bubble_done", 32'(bubble_ex), 32'd0);
    tick();
    check_eq("t2_sel1_wb_mem", 32'(forward_csr_signal1), 32'd3);
    drain();

    // 3: csrw mscratch then csrr mscratch with 0/1/2 gaps
    for (int gap = 0; gap < 3; gap++) begin
      id_csr(5'd7, 12'h340, 5'd0, 1'b1);
      tick();
      id_clear();
      repeat (gap) tick();
      id_csr(5'd0, 12'h340, 5'd8, 1'b0);
      tick();
      check_eq($sformatf("t3_sel2_gap%0d", gap), 32'(forward_csr_signal2), 32'(gap + 1));
      check_eq($sformatf("t3_sel1_gap%0d", gap), 32'(forward_csr_signal1), 32'd0);
      drain();
    end

    // 4a: producer writes x0, consumer reads x0
    id_alu(5'd0);
    tick();
    id_csr(5'd0, 12'h300, 5'd0, 1'b1);
    tick();
    check_eq("t4_x0_sel1", 32'(forward_csr_signal1), 32'd0);
    drain();

    // 4b: load-use hazard coinciding with flush
    id_load(5'd6);
    tick();
    id_csr(5'd6, 12'h305, 5'd0, 1'b1);
    flush = 1'b1;
    #1 check_eq("t4_flush_no_stall", 32'(stall_id), 32'd0);
    check_eq("t4_flush_no_bubble", 32'(bubble_ex), 32'd0);
    tick();
    flush = 1'b0;
    id_clear();
    check_eq("t4_flush_sel1", 32'(forward_csr_signal1), 32'd0);
    check_eq("t4_flush_sel2", 32'(forward_csr_signal2), 32'd0);
    id_load(5'd9);
    tick();
    id_csr(5'd9, 12'h305, 5'd0, 1'b1);
    #1 check_eq("t4_run_after_flush", 32'(stall_id), 32'd1);
    tick();
    tick();
    drain();

    // 5: hold for three cycles while in STALL
    id_load(5'd6);
    tick();
    id_csr(5'd6, 12'h305, 5'd0, 1'b1);
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("t5_hold%0d_stall", i), 32'(stall_id), 32'd0);
      check_eq($sformatf("t5_hold%0d_sel1", i), 32'(forward_csr_signal1), 32'd0);
    end
    hold = 1'b0;
    tick();
    check_eq("t5_release_sel1", 32'(forward_csr_signal1), 32'd3);
    drain();

    // 6: reset asserted while in STALL
    id_load(5'd6);
    tick();
    id_csr(5'd6, 12'h305, 5'd0, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    check_eq("t6_rst_stall", 32'(stall_id), 32'd0);
    check_eq("t6_rst_bubble", 32'(bubble_ex), 32'd0);
    check_eq("t6_rst_sel1", 32'(forward_csr_signal1), 32'd0);
    check_eq("t6_rst_sel2", 32'(forward_csr_signal2), 32'd0);
    check_eq("t6_rst_stat_stalls", stat_stalls, 32'd0);
    check_eq("t6_rst_stat_fwd", stat_fwd, 32'd0);
    #1 rst = 1'b0;
    #1 check_eq("t6_no_residual_stall", 32'(stall_id), 32'd0);
    tick();
    check_eq("t6_shadow_cleared_sel1", 32'(forward_csr_signal1), 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
